// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two-requester round-robin arbiter that sequences the
// APB SETUP/ACCESS phases toward a single shared slave. A watchdog aborts
// any transfer whose slave never raises ready.
module apb_req_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              wr0,
  input  logic              wr1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              tmo,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wr,
  output logic              m_sel,
  output logic              m_enable,
  input  logic              m_ready,
  input  logic              m_slverr,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Watchdog value reached at the start of the last permitted wait cycle.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic       last_gnt;
  logic [7:0] wdog;
  logic       grant;
  logic       winner;
  logic       finish;
  logic       expire;

  // State register; reset abandons any transfer in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, APB phase strobes and the grant/complete/abort decisions.
  always_comb begin
    state_nxt = state;
    m_sel     = 1'b0;
    m_enable  = 1'b0;
    grant     = 1'b0;
    winner    = 1'b0;
    finish    = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          winner    = (req0 && req1) ? ~last_gnt : req1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        m_sel     = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        m_sel    = 1'b1;
        m_enable = 1'b1;
        if (m_ready) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else if (wdog == WD_LAST) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant/transfer latches, watchdog and the one-cycle completion status.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
      gnt      <= 2'b00;
      done     <= 2'b00;
      rdata    <= '0;
      err      <= 1'b0;
      tmo      <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wr     <= 1'b0;
      wdog     <= 8'd0;
    end else begin
      done <= 2'b00;
      err  <= 1'b0;
      tmo  <= 1'b0;
      if (grant) begin
        gnt      <= winner ? 2'b10 : 2'b01;
        last_gnt <= winner;
        m_addr   <= winner ? addr1 : addr0;
        m_wdata  <= winner ? wdata1 : wdata0;
        m_wr     <= winner ? wr1 : wr0;
      end
      if (state == SETUP) begin
        wdog <= 8'd0;
      end else if (state == ACCESS && !m_ready) begin
        wdog <= wdog + 8'd1;
      end
      if (finish) begin
        if (!m_wr) rdata <= m_rdata;
        err  <= m_slverr;
        tmo  <= 1'b0;
        done <= gnt;
        gnt  <= 2'b00;
      end
      if (expire) begin
        err  <= 1'b1;
        tmo  <= 1'b1;
        done <= gnt;
        gnt  <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: drives both requesters against a behavioural APB RAM
// slave with adjustable wait states, and scores every done pulse against
// expectations queued when the request was issued.
module tb_apb_req_arbiter;

  localparam int TMO = 4;

  typedef struct {
    logic [1:0] done;
    logic [7:0] rdata;
    logic       err;
    logic       tmo;
  } sb_entry_t;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       wr0, wr1;
  logic [1:0] gnt, done;
  logic [7:0] rdata;
  logic       err, tmo;
  logic [3:0] m_addr;
  logic [7:0] m_wdata;
  logic       m_wr, m_sel, m_enable;
  logic       m_ready, m_slverr;
  logic [7:0] m_rdata;

  sb_entry_t  sb[$];
  logic [7:0] refMem[16];
  logic [7:0] slvMem[16];
  logic [7:0] expRdata;
  logic       lastGnt;
  int         accessCnt;
  int         waitCycles;
  bit         stallSlave;
  bit         slvErrMode;
  int         vectors;
  int         miscompares;

  apb_req_arbiter #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .wr0(wr0), .wr1(wr1),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err), .tmo(tmo),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wr(m_wr),
    .m_sel(m_sel), .m_enable(m_enable),
    .m_ready(m_ready), .m_slverr(m_slverr), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: ready after waitCycles ACCESS cycles unless stalled.
  assign m_ready  = m_sel && m_enable && !stallSlave && (accessCnt == waitCycles);
  assign m_slverr = m_ready && slvErrMode;
  assign m_rdata  = slvMem[m_addr];

  // Slave wait counter and RAM write port; errored writes are dropped.
  always @(posedge clk) begin
    if (m_sel && m_enable && !m_ready) accessCnt <= accessCnt + 1;
    else                               accessCnt <= 0;
    if (m_ready && m_wr && !slvErrMode) slvMem[m_addr] <= m_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Completion monitor: each done pulse is matched to the oldest expectation.
  always @(negedge clk) begin
    if (done !== 2'b00) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected done", {30'd0, done}, 32'd0);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        checkOutput("done", {30'd0, done}, {30'd0, e.done});
        checkOutput("rdata", {24'd0, rdata}, {24'd0, e.rdata});
        checkOutput("err", {31'd0, err}, {31'd0, e.err});
        checkOutput("tmo", {31'd0, tmo}, {31'd0, e.tmo});
      end
    end
  end

  task automatic applyStimulus(input int who, input logic [3:0] a, input logic [7:0] d, input logic w);
    if (who == 0) begin
      req0 = 1'b1; addr0 = a; wdata0 = d; wr0 = w;
    end else begin
      req1 = 1'b1; addr1 = a; wdata1 = d; wr1 = w;
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " gnt"}, {30'd0, gnt}, 32'd0);
    checkOutput({tag, " done"}, {30'd0, done}, 32'd0);
    checkOutput({tag, " rdata"}, {24'd0, rdata}, 32'd0);
    checkOutput({tag, " err/tmo"}, {30'd0, err, tmo}, 32'd0);
    checkOutput({tag, " sel/en"}, {30'd0, m_sel, m_enable}, 32'd0);
    checkOutput({tag, " m_wr"}, {31'd0, m_wr}, 32'd0);
    checkOutput({tag, " m_addr"}, {28'd0, m_addr}, 32'd0);
    checkOutput({tag, " m_wdata"}, {24'd0, m_wdata}, 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    lastGnt  = 1'b1;
    expRdata = 8'h00;
  endtask

  // One transfer from a single requester, checking phases, latency and wait count.
  task automatic runXfer(input int who, input logic [3:0] a, input logic [7:0] d, input logic w,
                         input int waitC, input bit stall, input bit serr);
    sb_entry_t e;
    int cyc, acc, expLat, expAcc;
    bit seen;
    waitCycles = waitC; stallSlave = stall; slvErrMode = serr;
    applyStimulus(who, a, d, w);
    e.done = (who == 0) ? 2'b01 : 2'b10;
    if (stall) begin
      e.err = 1'b1; e.tmo = 1'b1;
    end else begin
      e.err = serr; e.tmo = 1'b0;
      if (!w)        expRdata = refMem[a];
      else if (!serr) refMem[a] = d;
    end
    e.rdata = expRdata;
    sb.push_back(e);
    lastGnt = (who != 0);
    expLat  = stall ? 2 + TMO : 3 + waitC;
    expAcc  = stall ? TMO : waitC + 1;
    seen = 0; cyc = 0; acc = 0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        checkOutput("setup gnt", {30'd0, gnt}, {30'd0, e.done});
        checkOutput("setup sel/en", {30'd0, m_sel, m_enable}, 32'd2);
        checkOutput("setup addr", {28'd0, m_addr}, {28'd0, a});
        checkOutput("setup wr", {31'd0, m_wr}, {31'd0, w});
        if (w) checkOutput("setup wdata", {24'd0, m_wdata}, {24'd0, d});
      end
      if (cyc == 2) checkOutput("access sel/en", {30'd0, m_sel, m_enable}, 32'd3);
      if (m_enable) acc++;
      if (done !== 2'b00) seen = 1;
    end
    checkOutput("done seen", {31'd0, seen}, 32'd1);
    checkOutput("latency", cyc, expLat);
    checkOutput("access cycles", acc, expAcc);
    checkOutput("idle gap sel", {31'd0, m_sel}, 32'd0);
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    @(negedge clk);
    checkOutput("done one-shot", {30'd0, done}, 32'd0);
    checkOutput("err/tmo clear", {30'd0, err, tmo}, 32'd0);
    stallSlave = 0; slvErrMode = 0;
  endtask

  // Both requesters held high: requester 0 writes 3C to addr 5, requester 1 reads it.
  task automatic runContention(input int n);
    logic [1:0] expGnt[$];
    logic [1:0] prevGnt;
    sb_entry_t  e;
    int dn, gi, cyc;
    logic w;
    waitCycles = 1; stallSlave = 0; slvErrMode = 0;
    for (int k = 0; k < n; k++) begin
      w = ~lastGnt;
      e.done = w ? 2'b10 : 2'b01;
      e.err = 1'b0; e.tmo = 1'b0;
      if (w) expRdata = refMem[5];
      else   refMem[5] = 8'h3C;
      e.rdata = expRdata;
      sb.push_back(e);
      expGnt.push_back(e.done);
      lastGnt = w;
    end
    applyStimulus(0, 4'd5, 8'h3C, 1'b1);
    applyStimulus(1, 4'd5, 8'h00, 1'b0);
    prevGnt = gnt; dn = 0; gi = 0; cyc = 0;
    while (dn < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (prevGnt == 2'b00 && gnt != 2'b00) begin
        if (gi < n) checkOutput("rr grant", {30'd0, gnt}, {30'd0, expGnt[gi]});
        else        checkOutput("rr extra grant", {30'd0, gnt}, 32'd0);
        gi++;
      end
      prevGnt = gnt;
      if (done !== 2'b00) begin
        checkOutput("rr idle gap", {31'd0, m_sel}, 32'd0);
        dn++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("rr done count", dn, n);
    @(negedge clk);
    checkOutput("rr quiet", {30'd0, gnt}, 32'd0);
  endtask

  // Reset during ACCESS must leave no done pulse and restore the tie-break.
  task automatic resetMidAccess();
    waitCycles = 1; stallSlave = 1; slvErrMode = 0;
    applyStimulus(0, 4'd2, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("pre-reset access", {30'd0, m_sel, m_enable}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0; stallSlave = 0;
    lastGnt = 1'b1; expRdata = 8'h00;
    checkIdleOutputs("mid reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no done after reset", {30'd0, done}, 32'd0);
    end
    runContention(1);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; wr0 = 0; wr1 = 0;
    waitCycles = 1; stallSlave = 0; slvErrMode = 0;
    for (int i = 0; i < 16; i++) begin
      refMem[i] = 8'h00; slvMem[i] = 8'h00;
    end
    lastGnt = 1'b1; expRdata = 8'h00;
    doReset();
    runXfer(0, 4'd3, 8'hA5, 1'b1, 1, 0, 0);
    runXfer(1, 4'd3, 8'h00, 1'b0, 1, 0, 0);
    runXfer(0, 4'd3, 8'h00, 1'b0, TMO - 1, 0, 0);
    runXfer(1, 4'd3, 8'hFF, 1'b1, 1, 0, 1);
    runXfer(0, 4'd3, 8'h00, 1'b0, 0, 0, 0);
    runXfer(0, 4'd7, 8'h00, 1'b0, 0, 1, 0);
    doReset();
    runContention(4);
    resetMidAccess();
    for (int i = 0; i < 6; i++) begin
      runXfer(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0, 0);
    end
    repeat (2) @(negedge clk);
    checkOutput("scoreboard drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global time limit: simulation did not finish");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
